// File: rtl/hw_stack_if.sv
// Control-side bundle of the hw_stack LIFO: operation requests in, registered
// top-of-stack and status out.
interface hw_stack_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) ();
  logic                       push;
  logic                       pop;
  logic [DATA_W-1:0]          din;
  logic                       clr_err;
  logic [DATA_W-1:0]          dout;
  logic [$clog2(DEPTH):0]     level;
  logic                       empty;
  logic                       full;
  logic                       afull;
  logic                       ovf;
  logic                       unf;

  modport master (
    output push, pop, din, clr_err,
    input  dout, level, empty, full, afull, ovf, unf
  );

  modport slave (
    input  push, pop, din, clr_err,
    output dout, level, empty, full, afull, ovf, unf
  );
endinterface

// File: rtl/hw_stack.sv
// Parametrised LIFO with a dedicated top-of-stack register, saturating level,
// sticky overflow/underflow flags and an atomic replace-top (push+pop) operation.
module hw_stack #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AFULL  = DEPTH - 2
) (
  input  logic      clk,
  input  logic      reset,
  hw_stack_if.slave bus
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);

  // Entries below the top; index = level-2 for the entry just under dout.
  logic [DATA_W-1:0] mem [DEPTH-1];

  logic [DATA_W-1:0] dout_reg, dout_next;
  logic [LW-1:0]     level_reg, level_next;
  logic              ovf_reg, ovf_next;
  logic              unf_reg, unf_next;
  logic              wr_en;
  logic [LW-1:0]     level_m1, level_m2;
  logic [AW-1:0]     wr_idx, rd_idx;
  logic              empty_int, full_int;

  assign empty_int = (level_reg == '0);
  assign full_int  = (level_reg == LW'(DEPTH));
  assign level_m1  = level_reg - LW'(1);
  assign level_m2  = level_reg - LW'(2);
  assign wr_idx    = level_m1[AW-1:0];
  assign rd_idx    = level_m2[AW-1:0];

  always_comb begin
    dout_next  = dout_reg;
    level_next = level_reg;
    wr_en      = 1'b0;
    // Clear first so that a same-cycle set below takes precedence.
    ovf_next   = bus.clr_err ? 1'b0 : ovf_reg;
    unf_next   = bus.clr_err ? 1'b0 : unf_reg;
    unique case ({bus.push, bus.pop})
      2'b10: begin
        if (full_int) begin
          ovf_next = 1'b1;
        end else begin
          wr_en      = !empty_int;
          dout_next  = bus.din;
          level_next = level_reg + LW'(1);
        end
      end
      2'b01: begin
        if (empty_int) begin
          unf_next = 1'b1;
        end else begin
          dout_next  = (level_reg == LW'(1)) ? '0 : mem[rd_idx];
          level_next = level_m1;
        end
      end
      2'b11: begin
        dout_next = bus.din;
        if (empty_int) begin
          level_next = LW'(1);
          unf_next   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_reg  <= '0;
      level_reg <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      dout_reg  <= dout_next;
      level_reg <= level_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  // Array carries no reset so it can map onto RAM resources.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= dout_reg;
    end
  end

  assign bus.dout  = dout_reg;
  assign bus.level = level_reg;
  assign bus.empty = empty_int;
  assign bus.full  = full_int;
  assign bus.afull = (level_reg >= LW'(AFULL));
  assign bus.ovf   = ovf_reg;
  assign bus.unf   = unf_reg;
endmodule

// File: doc/hw_stack.md
# hw_stack

Parametrised LIFO stack for the RNBIP-2 processor, the successor of the fixed 8-bit call/return stack. It serves subroutine return addresses and operand spills. Width and depth are generic. Over the previous block it adds full/empty/almost-full status, sticky overflow and underflow error flags, and an atomic replace-top operation (push and pop in the same cycle). It sits between the control unit and the program counter / register file, and presents a registered top-of-stack.

## Interface
Parameters:
- DATA_W, 8: width of each stack entry.
- DEPTH, 16: number of entries; must be a power of two, ≥ 2.
- AFULL, DEPTH-2: level at or above which `afull` asserts; range 1..DEPTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- push  input  1  write `din` onto the stack this cycle.
- pop  input  1  remove the top entry this cycle.
- din  input  DATA_W  data to push.
- clr_err  input  1  clears `ovf` and `unf`.
- dout  output  DATA_W  registered top of stack; 0 when empty.
- level  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
- empty  output  1  level == 0.
- full  output  1  level == DEPTH.
- afull  output  1  level ≥ AFULL.
- ovf  output  1  sticky: a push was attempted while full.
- unf  output  1  sticky: a pop was attempted while empty.

## Operation
- Storage:
  - `dout` is a dedicated top-of-stack register.
  - Entries below the top live in a DEPTH-1 entry array indexed by `level`-2.
  - Array contents are not reset.
- Each cycle is decoded from {push, pop}:
  - 00 idle: no change.
  - 10 push, not full: the old `dout` goes into the array at index `level`-1 (skipped when empty). `dout` <= `din`, `level`+1.
  - 10 push, full: state unchanged, `ovf` <= 1; `din` is discarded.
  - 01 pop, not empty: `dout` <= array[`level`-2] (0 if `level` == 1), `level`-1.
  - 01 pop, empty: state unchanged, `unf` <= 1.
  - 11 replace, not empty: `dout` <= `din`; `level` and array unchanged. This works when full, with no `ovf`.
  - 11 replace, empty: executes as a push (`level` becomes 1, `dout` <= `din`) and sets `unf` <= 1.
- `empty`, `full` and `afull` are combinational decodes of the `level` register.
- `ovf` and `unf` are set only by the cases above.
  - They are cleared by `clr_err` or by reset.
  - If a set and `clr_err` occur in the same cycle, the set wins.
- Reset, asynchronous and valid at any time including mid-operation:
  - `level` = 0, `dout` = 0, `ovf` = 0, `unf` = 0.
  - Therefore `empty` = 1, `full` = 0, `afull` = 0.
  - Any operation in flight is lost. The first operation after deassertion is honoured on the first rising edge with reset low.
- No arithmetic wrap-around:
  - `level` saturates at 0 and DEPTH through the error cases.
  - The array index never leaves 0..DEPTH-2.

## Timing
- Single-cycle throughput; one operation per clock, back-to-back with no bubbles.
- Push-to-read latency 1 cycle: `din` sampled at edge N appears on `dout` immediately after edge N.
- Pop latency 1 cycle: the new top is visible after the edge that samples `pop`.
- `level` and the flags update on the same edge as `dout`.
- Status outputs are valid throughout the following cycle. Control logic may use `full` and `empty` combinationally to gate `push` and `pop` in that cycle.
- No combinational path from `push`/`pop`/`din` to any output.

## Test plan
- Reset and idle:
  - Assert `reset` asynchronously mid-cycle after 3 pushes → `dout`=0, `level`=0, `empty`=1, flags 0 without waiting for a clock edge.
  - Then 5 idle cycles → no change.
- Push/pop order (DATA_W=8, DEPTH=4):
  - Push 0xFA, 0xEF, 0x12 → `dout`=0x12, `level`=3.
  - Pop three times → `dout`=0xEF, 0xFA, 0x00; `empty`=1 after the third pop.
- Full and overflow (DEPTH=4, AFULL=2):
  - Push 1,2,3,4 → `afull` from `level`=2, `full`=1 at 4.
  - Push 5 → `ovf`=1, `dout`=4, `level`=4.
  - Pop four times → 3,2,1,0.
- Underflow and clear:
  - Pop when empty → `unf`=1, `level`=0.
  - `clr_err` together with another empty pop → `unf` stays 1.
  - `clr_err` alone → `unf`=0.
- Replace top:
  - Push 0xAA, 0xBB, then push+pop with `din`=0xCC → `dout`=0xCC, `level`=2.
  - Pop → 0xAA.
  - push+pop while empty with `din`=0x55 → `level`=1, `dout`=0x55, `unf`=1.
- Random back-to-back: 1000 cycles of random {push, pop, din} against a queue-based reference model; `dout`, `level` and all flags must match every cycle.
